// File: rtl/aoc_line_dispatcher.sv
// Feeds buffered bank lines one at a time to the digit-selection solver core,
// supervises each run with a watchdog and captures the puzzle total after the last line.
module aoc_line_dispatcher #(
    parameter int IN_WIDTH   = 336,
    parameter int OUT_WIDTH  = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int SUM_LAT    = 2,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    input  logic                 s_last,
    output logic                 core_rst,
    output logic                 core_start,
    output logic [IN_WIDTH-1:0]  core_num,
    input  logic                 core_done,
    input  logic [OUT_WIDTH-1:0] core_sum,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 result_valid,
    output logic [CNT_WIDTH-1:0] line_count,
    output logic                 busy,
    output logic                 err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int WD_W  = $clog2(TIMEOUT) + 1;
    localparam int SL_W  = $clog2(SUM_LAT + 1) + 1;

    localparam logic [PTR_W:0]       PTR_ONE  = (PTR_W + 1)'(1);
    localparam logic [WD_W-1:0]      WD_ONE   = WD_W'(1);
    localparam logic [WD_W-1:0]      WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [SL_W-1:0]      SL_ONE   = SL_W'(1);
    localparam logic [SL_W-1:0]      SL_LAST  = SL_W'(SUM_LAT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        START,
        WAIT,
        SETTLE,
        ERROR
    } state_t;

    state_t state_reg, state_next;

    // Each entry is {last flag, line}; one extra pointer bit separates full from empty.
    logic [IN_WIDTH:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr_reg, rd_ptr_reg;
    logic                   fifo_empty, fifo_full;
    logic                   push, pop;

    logic [IN_WIDTH-1:0]    core_num_reg;
    logic                   last_reg;
    logic [WD_W-1:0]        wd_reg;
    logic [SL_W-1:0]        settle_reg;
    logic [CNT_WIDTH-1:0]   line_count_reg;
    logic [OUT_WIDTH-1:0]   result_reg;
    logic                   result_valid_reg;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    assign s_ready = rst && !fifo_full && (state_reg != ERROR);
    assign push    = s_valid && s_ready;
    assign pop     = (state_reg == LOAD) && !fifo_empty;

    assign core_num     = core_num_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign line_count   = line_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // IDLE also looks at the incoming push so a line accepted into an empty
    // buffer starts the puzzle on the following cycle.
    always_comb begin
        state_next = state_reg;
        core_rst   = !rst;
        core_start = 1'b0;
        busy       = (state_reg != IDLE);
        err        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty || push) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                core_rst   = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                if (!fifo_empty) begin
                    state_next = START;
                end
            end
            START: begin
                core_start = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    state_next = last_reg ? SETTLE : LOAD;
                end else if (wd_reg == WD_LIMIT) begin
                    state_next = ERROR;
                end
            end
            SETTLE: begin
                if (settle_reg == SL_LAST) begin
                    state_next = IDLE;
                end
            end
            ERROR: begin
                core_rst = 1'b1;
                err      = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            core_num_reg     <= '0;
            last_reg         <= 1'b0;
            wd_reg           <= '0;
            settle_reg       <= '0;
            line_count_reg   <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg             <= rd_ptr_reg + PTR_ONE;
                {last_reg, core_num_reg} <= fifo_mem[rd_ptr_reg[PTR_W-1:0]];
            end
            case (state_reg)
                CLEAR: begin
                    line_count_reg   <= '0;
                    result_valid_reg <= 1'b0;
                end
                START: begin
                    wd_reg <= '0;
                end
                WAIT: begin
                    if (core_done) begin
                        if (line_count_reg != '1) begin
                            line_count_reg <= line_count_reg + CNT_ONE;
                        end
                        settle_reg <= '0;
                    end else begin
                        wd_reg <= wd_reg + WD_ONE;
                    end
                end
                SETTLE: begin
                    settle_reg <= settle_reg + SL_ONE;
                    // core_sum is valid only on the last settle cycle.
                    if (settle_reg == SL_LAST) begin
                        result_reg       <= core_sum;
                        result_valid_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aoc_line_dispatcher.sv
// Directed and randomised puzzles against a behavioural solver-core model and a
// string-based greedy reference for the expected puzzle totals.
module tb_aoc_line_dispatcher;
    localparam int IN_W    = 336;
    localparam int OUT_W   = 64;
    localparam int CNT_W   = 16;
    localparam int SUM_LAT = 2;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [IN_W-1:0]   s_data;
    logic              s_last;
    logic              core_rst;
    logic              core_start;
    logic [IN_W-1:0]   core_num;
    logic              core_done;
    logic [OUT_W-1:0]  core_sum;
    logic [OUT_W-1:0]  result;
    logic              result_valid;
    logic [CNT_W-1:0]  line_count;
    logic              busy;
    logic              err;

    aoc_line_dispatcher #(
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W),
        .FIFO_DEPTH(4),
        .SUM_LAT   (SUM_LAT),
        .TIMEOUT   (TIMEOUT),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .core_rst    (core_rst),
        .core_start  (core_start),
        .core_num    (core_num),
        .core_done   (core_done),
        .core_sum    (core_sum),
        .result      (result),
        .result_valid(result_valid),
        .line_count  (line_count),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [IN_W-1:0] data;
        bit              last;
    } item_t;

    item_t           tx_q[$];
    logic [IN_W-1:0] sb[$];
    int              fire_cyc_q[$];
    int              start_cyc_q[$];
    int              done_cyc_q[$];
    string           pz[$];

    int checks = 0;
    int errors = 0;

    int  lat = 20;
    int  gap_max = 0;
    bit  hang = 1'b0;
    bit  spur_req = 1'b0;
    bit  saw_bp = 1'b0;
    int  starts = 0;
    int  rv_rises = 0;
    int  rv_rise_cyc = 0;
    bit  rv_rise_busy = 1'b0;
    int  cr_rises = 0;

    task automatic chk(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] to_num(input string s);
        logic [IN_W-1:0] v = '0;
        for (int i = 0; i < s.len(); i++) v = v * 10 + IN_W'(s[i] - 8'd48);
        return v;
    endfunction

    // Reference: pick 12 digits greedily, each the largest that still leaves room.
    function automatic logic [63:0] ref_select12(input string s);
        int pos = 0;
        int best;
        logic [63:0] v = '0;
        for (int k = 0; k < 12; k++) begin
            best = pos;
            for (int i = pos; i <= s.len() - 12 + k; i++) if (s[i] > s[best]) best = i;
            v = v * 10 + 64'(s[best] - 8'd48);
            pos = best + 1;
        end
        return v;
    endfunction

    // Core model: decimal digits of the operand, monotonic-stack removal.
    function automatic logic [63:0] core_eval(input logic [IN_W-1:0] n);
        int d[$];
        int stk[$];
        int drop;
        logic [IN_W-1:0] t = n;
        logic [IN_W-1:0] r;
        logic [63:0] v = '0;
        while (t != 0) begin
            r = t % 10;
            d.push_front(int'(r[3:0]));
            t = t / 10;
        end
        drop = d.size() - 12;
        foreach (d[i]) begin
            while (drop > 0 && stk.size() > 0 && stk[$] < d[i]) begin
                void'(stk.pop_back());
                drop--;
            end
            stk.push_back(d[i]);
        end
        for (int k = 0; k < 12; k++) v = v * 10 + 64'(stk[k]);
        return v;
    endfunction

    function automatic string rand_line();
        string s = "";
        int n = $urandom_range(12, 20);
        for (int i = 0; i < n; i++) s = $sformatf("%s%0d", s, $urandom_range(1, 9));
        return s;
    endfunction

    task automatic gen_pz(input int n);
        pz.delete();
        for (int i = 0; i < n; i++) pz.push_back(rand_line());
    endtask

    task automatic enqueue_pz(input bit mark_last, output logic [63:0] exp);
        item_t it;
        exp = '0;
        foreach (pz[i]) begin
            it.data = to_num(pz[i]);
            it.last = mark_last && (i == pz.size() - 1);
            tx_q.push_back(it);
            exp = exp + ref_select12(pz[i]);
        end
    endtask

    task automatic wait_result(input int snap, input int budget, input string tag);
        int n = 0;
        while (rv_rises == snap && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_in_time"}, IN_W'(rv_rises != snap), IN_W'(1));
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, IN_W'(s_ready), '0);
        chk({tag, "_core_rst"}, IN_W'(core_rst), IN_W'(1));
        chk({tag, "_core_start"}, IN_W'(core_start), '0);
        chk({tag, "_core_num"}, core_num, '0);
        chk({tag, "_result"}, IN_W'(result), '0);
        chk({tag, "_result_valid"}, IN_W'(result_valid), '0);
        chk({tag, "_line_count"}, IN_W'(line_count), '0);
        chk({tag, "_busy"}, IN_W'(busy), '0);
        chk({tag, "_err"}, IN_W'(err), '0);
    endtask

    // Line source: presents tx_q entries with optional idle gaps, one per handshake.
    initial begin
        item_t it;
        int gap = 0;
        bit fire = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                s_valid = 1'b0;
                fire    = 1'b0;
            end else begin
                if (fire) begin
                    s_valid = 1'b0;
                    fire    = 1'b0;
                end
                if (!s_valid) begin
                    if (gap > 0) gap--;
                    else if (tx_q.size() > 0) begin
                        it      = tx_q.pop_front();
                        s_valid = 1'b1;
                        s_data  = it.data;
                        s_last  = it.last;
                        gap     = $urandom_range(0, gap_max);
                    end
                end
                if (s_valid && s_ready) begin
                    fire = 1'b1;
                    sb.push_back(s_data);
                    fire_cyc_q.push_back(cyc);
                end
                if (s_valid && !s_ready) saw_bp = 1'b1;
            end
        end
    end

    // Solver-core model: fixed latency, running total visible SUM_LAT cycles after done.
    initial begin
        logic [IN_W-1:0] cur_num = '0;
        logic [IN_W-1:0] exp_num;
        logic [63:0] acc = '0;
        int cnt = 0;
        int pipe = 0;
        bit running = 1'b0;
        core_done = 1'b0;
        core_sum  = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (core_rst) begin
                acc      = '0;
                core_sum = '0;
                cnt      = 0;
                pipe     = 0;
                running  = 1'b0;
            end else begin
                if (pipe > 0) begin
                    pipe--;
                    if (pipe == 0) core_sum = acc;
                end
                if (running) begin
                    chk("core_num_stable", core_num, cur_num);
                    cnt--;
                    if (cnt == 0) begin
                        core_done = 1'b1;
                        running   = 1'b0;
                        acc       = acc + core_eval(cur_num);
                        pipe      = SUM_LAT;
                        done_cyc_q.push_back(cyc);
                    end
                end
                if (core_start) begin
                    starts++;
                    start_cyc_q.push_back(cyc);
                    if (sb.size() == 0) begin
                        chk("line_order_underflow", IN_W'(1), '0);
                    end else begin
                        exp_num = sb.pop_front();
                        chk("line_order", core_num, exp_num);
                    end
                    cur_num = core_num;
                    if (!hang) begin
                        running = 1'b1;
                        cnt     = lat;
                    end
                end
                if (spur_req) begin
                    core_done = 1'b1;
                    spur_req  = 1'b0;
                end
            end
        end
    end

    initial begin
        bit rv_prev = 1'b0;
        bit cr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (result_valid && !rv_prev) begin
                rv_rises++;
                rv_rise_cyc  = cyc;
                rv_rise_busy = busy;
            end
            rv_prev = result_valid;
            if (core_rst && !cr_prev) cr_rises++;
            cr_prev = core_rst;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    logic [63:0] exp_a, exp_b;
    int snap, crs, lc_snap, n, err_cyc;
    item_t it_main;

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", IN_W'(s_ready), IN_W'(1));
        chk("post_rst_core_rst", IN_W'(core_rst), '0);

        // Four example lines.
        fire_cyc_q.delete(); start_cyc_q.delete(); done_cyc_q.delete();
        starts = 0; lat = 20; gap_max = 0;
        snap = rv_rises; crs = cr_rises;
        pz = '{"987654321111111", "811111111111119", "234234234234278", "818181911112111"};
        enqueue_pz(1'b1, exp_a);
        wait_result(snap, 400, "ex");
        chk("ex_result", IN_W'(result), IN_W'(64'd3121910778619));
        chk("ex_result_ref", IN_W'(result), IN_W'(exp_a));
        chk("ex_result_valid", IN_W'(result_valid), IN_W'(1));
        chk("ex_line_count", IN_W'(line_count), IN_W'(4));
        chk("ex_starts", IN_W'(starts), IN_W'(4));
        chk("ex_first_start_lat", IN_W'(start_cyc_q[0] - fire_cyc_q[0]), IN_W'(3));
        chk("ex_done_to_start", IN_W'(start_cyc_q[1] - done_cyc_q[0]), IN_W'(2));
        chk("ex_done_to_rv", IN_W'(rv_rise_cyc - done_cyc_q[3]), IN_W'(SUM_LAT + 1));
        chk("ex_busy_at_rv", IN_W'(rv_rise_busy), '0);
        chk("ex_rv_rises", IN_W'(rv_rises - snap), IN_W'(1));
        chk("ex_core_rst_pulses", IN_W'(cr_rises - crs), IN_W'(1));

        // Eight back-to-back lines against a slow core.
        lat = 50; saw_bp = 1'b0; snap = rv_rises;
        gen_pz(8);
        enqueue_pz(1'b1, exp_a);
        wait_result(snap, 1000, "b2b");
        chk("b2b_result", IN_W'(result), IN_W'(exp_a));
        chk("b2b_line_count", IN_W'(line_count), IN_W'(8));
        chk("b2b_backpressure", IN_W'(saw_bp), IN_W'(1));
        chk("b2b_all_consumed", IN_W'(sb.size()), '0);

        // Single-line puzzle followed by a second puzzle.
        lat = 15; snap = rv_rises; crs = cr_rises;
        gen_pz(1);
        enqueue_pz(1'b1, exp_a);
        wait_result(snap, 200, "one");
        chk("one_result", IN_W'(result), IN_W'(exp_a));
        chk("one_line_count", IN_W'(line_count), IN_W'(1));
        snap = rv_rises;
        gen_pz(2);
        enqueue_pz(1'b1, exp_b);
        n = 0;
        while (core_rst !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("two_clear_seen", IN_W'(core_rst), IN_W'(1));
        chk("two_rv_held_in_clear", IN_W'(result_valid), IN_W'(1));
        @(negedge clk);
        chk("two_rv_dropped", IN_W'(result_valid), '0);
        wait_result(snap, 300, "two");
        chk("two_result", IN_W'(result), IN_W'(exp_b));
        chk("two_line_count", IN_W'(line_count), IN_W'(2));
        chk("two_core_rst_pulses", IN_W'(cr_rises - crs), IN_W'(2));

        // Spurious done while idle, then while parked in LOAD between lines.
        lc_snap = int'(line_count);
        spur_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("spur_idle_line_count", IN_W'(line_count), IN_W'(lc_snap));
        chk("spur_idle_busy", IN_W'(busy), '0);
        snap = rv_rises;
        gen_pz(1);
        enqueue_pz(1'b0, exp_a);
        n = 0;
        while (line_count !== CNT_W'(1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("spur_load_busy", IN_W'(busy), IN_W'(1));
        spur_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("spur_load_line_count", IN_W'(line_count), IN_W'(1));
        gen_pz(1);
        enqueue_pz(1'b1, exp_b);
        wait_result(snap, 200, "spur");
        chk("spur_result", IN_W'(result), IN_W'(exp_a + exp_b));
        chk("spur_line_count", IN_W'(line_count), IN_W'(2));

        // Done on the last permitted WAIT cycle beats the watchdog.
        lat = TIMEOUT; snap = rv_rises;
        gen_pz(1);
        enqueue_pz(1'b1, exp_a);
        wait_result(snap, 300, "edge");
        chk("edge_err", IN_W'(err), '0);
        chk("edge_result", IN_W'(result), IN_W'(exp_a));

        // Core hang: watchdog fires after TIMEOUT WAIT cycles.
        hang = 1'b1;
        gen_pz(1);
        enqueue_pz(1'b1, exp_a);
        n = 0; err_cyc = -1;
        while (err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (err === 1'b1) err_cyc = cyc;
        chk("hang_err", IN_W'(err), IN_W'(1));
        chk("hang_err_latency", IN_W'(err_cyc - start_cyc_q[$]), IN_W'(TIMEOUT + 1));
        repeat (5) @(negedge clk);
        chk("hang_err_sticky", IN_W'(err), IN_W'(1));
        chk("hang_core_rst", IN_W'(core_rst), IN_W'(1));
        chk("hang_s_ready", IN_W'(s_ready), '0);
        #2 rst = 1'b0;
        #1 check_reset_outputs("hang_rst");
        hang = 1'b0;
        tx_q.delete(); sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-WAIT, then a clean puzzle.
        lat = 50; gap_max = 0;
        gen_pz(3);
        enqueue_pz(1'b1, exp_a);
        snap = starts;
        n = 0;
        while (starts < snap + 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("mid_in_wait", IN_W'(busy), IN_W'(1));
        #2 rst = 1'b0;
        #1 check_reset_outputs("mid_rst");
        tx_q.delete(); sb.delete();
        @(negedge clk);
        rst = 1'b1;
        lat = 10; gap_max = 2; snap = rv_rises;
        gen_pz(3);
        enqueue_pz(1'b1, exp_a);
        wait_result(snap, 400, "restart");
        chk("restart_result", IN_W'(result), IN_W'(exp_a));
        chk("restart_line_count", IN_W'(line_count), IN_W'(3));

        // Randomised puzzles.
        for (int p = 0; p < 4; p++) begin
            lat = $urandom_range(3, 30);
            gap_max = $urandom_range(0, 3);
            snap = rv_rises;
            n = $urandom_range(1, 6);
            gen_pz(n);
            enqueue_pz(1'b1, exp_a);
            wait_result(snap, 2000, "rand");
            chk("rand_result", IN_W'(result), IN_W'(exp_a));
            chk("rand_line_count", IN_W'(line_count), IN_W'(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
